// File: rtl/dc_sweep_sequencer.sv
// DC operating-point sweep sequencer: ramps the source DAC, settles, converts and streams records.
// Build option: define DC_SWEEP_AVG_EN to average four conversions per point.
module dc_sweep_sequencer #(
  parameter int DAC_W    = 12,
  parameter int ADC_W    = 12,
  parameter int PTS_W    = 8,
  parameter int SETTLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DAC_W-1:0]    cfg_start_code,
  input  logic [DAC_W-1:0]    cfg_step_code,
  input  logic [PTS_W-1:0]    cfg_num_points,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PTS_W-1:0]    res_index,
  output logic [DAC_W-1:0]    res_code,
  output logic [ADC_W-1:0]    res_data,
  output logic                busy,
  output logic                done,
  output logic                sat
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CONVERT, S_EMIT, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [PTS_W-1:0]    index_reg, index_next;
  logic [DAC_W-1:0]    code_reg, code_next;
  logic [DAC_W-1:0]    step_reg, step_next;
  logic [PTS_W-1:0]    num_points_reg, num_points_next;
  logic [SETTLE_W-1:0] settle_cfg_reg, settle_cfg_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [DAC_W-1:0]    dac_code_reg, dac_code_next;
  logic                dac_load_reg, dac_load_next;
  logic                adc_req_reg, adc_req_next;
  logic                res_valid_reg, res_valid_next;
  logic [ADC_W-1:0]    res_data_reg, res_data_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                sat_reg, sat_next;
`ifdef DC_SWEEP_AVG_EN
  logic [ADC_W+1:0]    acc_reg, acc_next;
  logic [1:0]          avg_cnt_reg, avg_cnt_next;
  logic [ADC_W+1:0]    acc_sum;
`endif

  logic                ack_take;
  logic                handshake;
  logic [DAC_W:0]      code_sum;

  // An ack is honoured only while a request is actually outstanding.
  assign ack_take  = (state_reg == S_CONVERT) && adc_req_reg && adc_ack;
  assign handshake = (state_reg == S_EMIT) && res_valid_reg && res_ready;
  assign code_sum  = {1'b0, code_reg} + {1'b0, step_reg};
`ifdef DC_SWEEP_AVG_EN
  assign acc_sum   = acc_reg + {2'b00, adc_data};
`endif

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    code_next       = code_reg;
    step_next       = step_reg;
    num_points_next = num_points_reg;
    settle_cfg_next = settle_cfg_reg;
    settle_cnt_next = settle_cnt_reg;
    dac_code_next   = dac_code_reg;
    dac_load_next   = 1'b0;
    adc_req_next    = 1'b0;
    res_valid_next  = 1'b0;
    res_data_next   = res_data_reg;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    sat_next        = sat_reg;
`ifdef DC_SWEEP_AVG_EN
    acc_next        = acc_reg;
    avg_cnt_next    = avg_cnt_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          step_next       = cfg_step_code;
          num_points_next = cfg_num_points;
          settle_cfg_next = cfg_settle;
          sat_next        = 1'b0;
          index_next      = '0;
          code_next       = cfg_start_code;
          state_next      = (cfg_num_points == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        settle_cnt_next = settle_cfg_reg - SETTLE_W'(1);
        state_next      = (settle_cfg_reg == '0) ? S_CONVERT : S_SETTLE;
`ifdef DC_SWEEP_AVG_EN
        acc_next        = '0;
        avg_cnt_next    = '0;
`endif
      end
      S_SETTLE: begin
        if (settle_cnt_reg == '0) begin
          state_next = S_CONVERT;
        end else begin
          settle_cnt_next = settle_cnt_reg - SETTLE_W'(1);
        end
      end
      S_CONVERT: begin
        if (ack_take) begin
`ifdef DC_SWEEP_AVG_EN
          acc_next = acc_sum;
          if (avg_cnt_reg == 2'd3) begin
            res_data_next = acc_sum[ADC_W+1:2];
            state_next    = S_EMIT;
          end else begin
            avg_cnt_next = avg_cnt_reg + 2'd1;
          end
`else
          res_data_next = adc_data;
          state_next    = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (handshake) begin
          if (index_reg == num_points_reg - PTS_W'(1)) begin
            state_next = S_DONE;
          end else begin
            index_next = index_reg + PTS_W'(1);
            state_next = S_LOAD;
            if (code_sum[DAC_W]) begin
              code_next = {DAC_W{1'b1}};
              sat_next  = 1'b1;
            end else begin
              code_next = code_sum[DAC_W-1:0];
            end
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
    res_valid_next = (state_next == S_EMIT);
    adc_req_next   = (state_next == S_CONVERT) && !ack_take;
    if (state_next == S_LOAD) begin
      dac_load_next = 1'b1;
      dac_code_next = code_next;
    end

    // Abort drops everything in flight and parks the source at code 0.
    if (abort && state_reg != S_IDLE) begin
      state_next     = S_IDLE;
      index_next     = index_reg;
      code_next      = code_reg;
      sat_next       = sat_reg;
      busy_next      = 1'b0;
      done_next      = 1'b0;
      res_valid_next = 1'b0;
      adc_req_next   = 1'b0;
      dac_code_next  = '0;
      dac_load_next  = 1'b1;
`ifdef DC_SWEEP_AVG_EN
      acc_next       = '0;
      avg_cnt_next   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      index_reg      <= '0;
      code_reg       <= '0;
      step_reg       <= '0;
      num_points_reg <= '0;
      settle_cfg_reg <= '0;
      settle_cnt_reg <= '0;
      dac_code_reg   <= '0;
      dac_load_reg   <= 1'b0;
      adc_req_reg    <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      sat_reg        <= 1'b0;
`ifdef DC_SWEEP_AVG_EN
      acc_reg        <= '0;
      avg_cnt_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      code_reg       <= code_next;
      step_reg       <= step_next;
      num_points_reg <= num_points_next;
      settle_cfg_reg <= settle_cfg_next;
      settle_cnt_reg <= settle_cnt_next;
      dac_code_reg   <= dac_code_next;
      dac_load_reg   <= dac_load_next;
      adc_req_reg    <= adc_req_next;
      res_valid_reg  <= res_valid_next;
      res_data_reg   <= res_data_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      sat_reg        <= sat_next;
`ifdef DC_SWEEP_AVG_EN
      acc_reg        <= acc_next;
      avg_cnt_reg    <= avg_cnt_next;
`endif
    end
  end

  assign dac_code  = dac_code_reg;
  assign dac_load  = dac_load_reg;
  assign adc_req   = adc_req_reg;
  assign res_valid = res_valid_reg;
  assign res_index = index_reg;
  assign res_code  = code_reg;
  assign res_data  = res_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign sat       = sat_reg;

endmodule
